// File: rtl/execution_controller_if.sv
// Operator/control-unit side of the execution controller: raw buttons, decode
// flags in; commit strobe and status out.
interface execution_controller_if;
  logic        button_step;
  logic        button_confirm;
  logic        run_mode;
  logic        halt;
  logic        input_request;
  logic        cpu_enable;
  logic        input_ready;
  logic        waiting_input;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] step_count;

  modport master (
    output button_step, button_confirm, run_mode, halt, input_request,
    input  cpu_enable, input_ready, waiting_input, halted, state, step_count
  );

  modport slave (
    input  button_step, button_confirm, run_mode, halt, input_request,
    output cpu_enable, input_ready, waiting_input, halted, state, step_count
  );
endinterface

// File: rtl/execution_controller.sv
// Turns step/confirm buttons and run mode into one-cycle cpu_enable commit
// pulses; stalls on input instructions and freezes on HALT.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;
  logic          stable, stable_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_pipe <= '0;
      cnt       <= '0;
      stable    <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      stable_q  <= stable;
      // level must differ from the accepted one for DEBOUNCE_CYCLES edges
      if (sync_pipe[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_pipe[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_q;
endmodule

module execution_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIVIDE      = 4
) (
  input logic                  clock,
  input logic                  reset,
  execution_controller_if.slave bus
);
  localparam int NUM_BTN = 2;
  localparam int DW      = (RUN_DIVIDE > 1) ? $clog2(RUN_DIVIDE) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ISSUE      = 2'b01,
    WAIT_INPUT = 2'b10,
    HALTED     = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] raw_btn, press;
  logic               step_press, confirm_press;

  assign raw_btn = {bus.button_confirm, bus.button_step};

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock (clock),
        .reset (reset),
        .raw   (raw_btn[i]),
        .press (press[i])
      );
    end
  endgenerate

  assign step_press    = press[0];
  assign confirm_press = press[1];

  state_t        state_q;
  logic [DW-1:0] div;
  logic [15:0]   step_count_q;
  logic          cpu_enable_q, input_ready_q, waiting_q, halted_q;
  logic          div_done, trigger;

  assign div_done = (div == DW'(RUN_DIVIDE - 1));
  assign trigger  = bus.run_mode ? div_done : step_press;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      div           <= '0;
      step_count_q  <= '0;
      cpu_enable_q  <= 1'b0;
      input_ready_q <= 1'b0;
      waiting_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      cpu_enable_q  <= 1'b0;
      input_ready_q <= 1'b0;

      if (state_q == ISSUE && step_count_q != 16'hFFFF)
        step_count_q <= step_count_q + 16'd1;

      if (state_q == IDLE && bus.run_mode)
        div <= div_done ? '0 : div + 1'b1;
      else
        div <= '0;

      // outputs are registered alongside the state they decode
      case (state_q)
        IDLE: begin
          if (trigger) begin
            if (bus.halt) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else if (bus.input_request) begin
              state_q   <= WAIT_INPUT;
              waiting_q <= 1'b1;
            end else begin
              state_q      <= ISSUE;
              cpu_enable_q <= 1'b1;
            end
          end
        end
        ISSUE: state_q <= IDLE;
        WAIT_INPUT: begin
          if (confirm_press) begin
            state_q       <= ISSUE;
            cpu_enable_q  <= 1'b1;
            input_ready_q <= 1'b1;
            waiting_q     <= 1'b0;
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_enable    = cpu_enable_q;
  assign bus.input_ready   = input_ready_q;
  assign bus.waiting_input = waiting_q;
  assign bus.halted        = halted_q;
  assign bus.state         = state_q;
  assign bus.step_count    = step_count_q;
endmodule

// File: doc/execution_controller.md
# execution_controller

Sequencing controller for the single-cycle processing unit. It turns the raw step and confirm buttons plus the run-mode switch into one-cycle `cpu_enable` commit pulses, so the datapath advances exactly one instruction per pulse. It stalls on input instructions until the operator confirms the switch value, and freezes permanently on halt. It replaces the free-running divided clock: the core runs on `clock` and gates its PC, register, memory and output writes with `cpu_enable`.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a button level change; must be ≥ 2.
- RUN_DIVIDE, 4: idle cycles between commits in run mode; must be ≥ 1.

- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; returns every register to its reset value.
- button_step  in  1  raw, asynchronous step button; high when pressed.
- button_confirm  in  1  raw, asynchronous input-confirm button; high when pressed.
- run_mode  in  1  1 = free run; 0 = single step.
- halt  in  1  current instruction is HALT (control unit decode).
- input_request  in  1  current instruction reads the switches.
- cpu_enable  out  1  one-cycle commit strobe to the datapath.
- input_ready  out  1  high only in a commit cycle that completes an input instruction.
- waiting_input  out  1  high while stalled for confirm.
- halted  out  1  high in HALTED.
- state  out  2  IDLE=00, ISSUE=01, WAIT_INPUT=10, HALTED=11.
- step_count  out  16  committed instructions; saturates at 0xFFFF.

## Operation
- Button conditioning is the same for each button:
  - 2-flop synchronizer, then debounce counter `cnt`, then debounced level `stable`.
  - `cnt` clears whenever the sync output equals `stable`.
  - Otherwise `cnt` increments. On an edge where `cnt == DEBOUNCE_CYCLES-1` and the values still differ, `stable` takes the sync value and `cnt` clears.
  - Press pulse = `stable & ~stable_q`, where `stable_q` is the previous `stable`. The pulse is one cycle wide. Release generates no pulse.
- Run divider `div`:
  - Counts only in IDLE with `run_mode = 1`.
  - Clears in every other state and whenever `run_mode = 0`.
- Trigger in IDLE:
  - `run_mode = 0`: step press pulse.
  - `run_mode = 1`: `div == RUN_DIVIDE-1`.
- FSM:
  - IDLE, on trigger: if `halt`, go to HALTED; else if `input_request`, go to WAIT_INPUT; else go to ISSUE. `halt` wins over `input_request`.
  - ISSUE: go to IDLE unconditionally.
  - WAIT_INPUT: on confirm press pulse, go to ISSUE and set flag `inp`. Step presses and `run_mode` are ignored here.
  - HALTED: absorbing; only `reset` exits.
- Outputs:
  - `cpu_enable = (state == ISSUE)`.
  - `input_ready = (state == ISSUE) & inp`; `inp` clears on leaving ISSUE.
  - `waiting_input = (state == WAIT_INPUT)`; `halted = (state == HALTED)`.
  - `step_count` increments at the end of each ISSUE cycle unless it is already 0xFFFF.
- Ignored events: confirm presses outside WAIT_INPUT; step presses in run mode, ISSUE or HALTED. No press is queued.

## Timing
- Reset values: state = IDLE, `cpu_enable = 0`, `input_ready = 0`, `waiting_input = 0`, `halted = 0`, `step_count = 0`, all `cnt`/`div` = 0, synchronizers = 0, `stable = stable_q = 0`.
- Button latency: count the first edge that samples the raw button high as edge 1.
  - `stable` rises at edge DEBOUNCE_CYCLES+2.
  - The FSM samples the pulse at edge DEBOUNCE_CYCLES+3; ISSUE or WAIT_INPUT holds during the following cycle.
- Glitches: a raw pulse shorter than DEBOUNCE_CYCLES sync cycles produces no press.
- Run mode: commit period is RUN_DIVIDE+1 cycles (ISSUE, then RUN_DIVIDE IDLE cycles).
- `halt` and `input_request` are sampled only on the trigger edge.
- Mode switch: `run_mode` 1→0 in IDLE clears `div`; the next commit needs a step press.
- Reset mid-operation: takes effect on the next edge from any state, including HALTED and WAIT_INPUT. A button still held through reset is seen as a new press DEBOUNCE_CYCLES+2 edges after reset deasserts.

## Test plan
- Single step, DEBOUNCE_CYCLES=16, `run_mode=0`, hold `button_step` for 40 cycles → one `cpu_enable` pulse, in the cycle after edge 19; `step_count=1`; state back to 00.
- Glitch: `button_step` high for 10 cycles, then low → no `cpu_enable`; `step_count` stays 0.
- Run mode, RUN_DIVIDE=4, `halt=0`, `input_request=0`, 50 cycles → `cpu_enable` every 5 cycles; `step_count` = number of pulses.
- Input stall: in run mode, raise `input_request` → state 10 and `waiting_input=1`. Step presses are ignored. Press confirm → one cycle with `cpu_enable=1` and `input_ready=1`, then IDLE.
- Halt priority: `halt=1` and `input_request=1` at the trigger → HALTED (`halted=1`), no `cpu_enable`, presses ignored. `reset` for 1 cycle → state 00 and all outputs 0.
- Saturation: force 65535 commits (or preload the counter in the bench) → `step_count` holds at 0xFFFF on further commits.
